// File: rtl/pc_unit.sv
// 6502 program counter: PCL/PCH registers, deferred low-to-high carry, ADL/ADH loads, bus drives.
// Build option: define PC_FAST_CARRY_EN for a single-cycle full-width increment.
module pc_unit #(
   parameter int                     LO_W     = 8,
   parameter int                     HI_W     = 8,
   parameter logic [LO_W+HI_W-1:0]   RESET_PC = (LO_W+HI_W)'(16'hFFFC)
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst,
   input  logic                                   i_inc,
   input  logic                                   i_pcl_load_adl,
   input  logic                                   i_pch_load_adh,
   input  logic [LO_W-1:0]                        i_adl_data,
   input  logic [HI_W-1:0]                        i_adh_data,
   input  logic                                   i_pcl_db_en,
   input  logic                                   i_pch_db_en,
   input  logic                                   i_pcl_adl_en,
   input  logic                                   i_pch_adh_en,
   output logic [((LO_W > HI_W) ? LO_W : HI_W)-1:0] o_db_out,
   output logic [LO_W-1:0]                        o_adl_out,
   output logic [HI_W-1:0]                        o_adh_out,
   output logic [LO_W+HI_W-1:0]                   o_pc_out,
   output logic                                   o_carry_pend
);

   // state    | meaning
   // ST_RUN   | no carry outstanding
   // ST_CARRY | PCL wrapped last edge; PCH increments on the next edge

   localparam int DB_W = (LO_W > HI_W) ? LO_W : HI_W;

   typedef enum logic {ST_RUN, ST_CARRY} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [LO_W-1:0]   r_pcl;
   logic [HI_W-1:0]   r_pch;
   logic [LO_W-1:0]   w_pcl_nxt;
   logic [HI_W-1:0]   w_pch_nxt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pcl   <= RESET_PC[LO_W-1:0];
         r_pch   <= RESET_PC[LO_W+HI_W-1:LO_W];
         r_state <= ST_RUN;
      end else begin
         r_pcl   <= w_pcl_nxt;
         r_pch   <= w_pch_nxt;
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_pcl_nxt   = r_pcl;
      w_pch_nxt   = r_pch;
      w_state_nxt = ST_RUN;
`ifdef PC_FAST_CARRY_EN
      // CARRY is never entered, so CARRY_PEND stays low in this build.
      if (i_inc)
         {w_pch_nxt, w_pcl_nxt} = {r_pch, r_pcl} + 1'b1;
      if (i_pcl_load_adl)
         w_pcl_nxt = i_adl_data;
      if (i_pch_load_adh)
         w_pch_nxt = i_adh_data;
`else
      if (i_pcl_load_adl)
         w_pcl_nxt = i_adl_data;
      else if (i_inc)
         w_pcl_nxt = r_pcl + 1'b1;
      if (r_state == ST_CARRY)
         w_pch_nxt = r_pch + 1'b1;
      // An ADH load overrides (and so drops) a pending carry.
      if (i_pch_load_adh)
         w_pch_nxt = i_adh_data;
      if (i_inc && !i_pcl_load_adl && (&r_pcl))
         w_state_nxt = ST_CARRY;
`endif
   end

   always_comb begin
      o_db_out     = '0;
      o_adl_out    = '0;
      o_adh_out    = '0;
      o_pc_out     = {r_pch, r_pcl};
      o_carry_pend = (r_state == ST_CARRY);
      if (i_pcl_db_en)
         o_db_out = DB_W'(r_pcl);
      else if (i_pch_db_en)
         o_db_out = DB_W'(r_pch);
      if (i_pcl_adl_en)
         o_adl_out = r_pcl;
      if (i_pch_adh_en)
         o_adh_out = r_pch;
   end

endmodule
